// File: rtl/cu_cache_response_collector.sv
// cu_cache_response_collector: pairs in-order cache responses with tracked commands.
// Optional CACHE_RESP_LATENCY_STATS_EN adds per-run latency stats (lat_max, lat_sum).
module cu_cache_response_collector #(
  parameter int TRK_DEPTH = 16,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 32,
  localparam int PW       = $clog2(TRK_DEPTH) + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  expected_count,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TAG_W-1:0]  cmd_tag,
  input  logic              cmd_is_read,
  input  logic              cache_resp_valid,
  output logic              cache_resp_ready,
  input  logic [DATA_W-1:0] cache_resp_data,
  output logic              resp_out_valid,
  input  logic              resp_out_ready,
  output logic [TAG_W-1:0]  resp_out_tag,
  output logic              resp_out_is_read,
  output logic [DATA_W-1:0] resp_out_data,
  output logic [PW-1:0]     pending_count,
  output logic              done
`ifdef CACHE_RESP_LATENCY_STATS_EN
  ,
  output logic [15:0]       lat_max,
  output logic [31:0]       lat_sum
`endif
);

  localparam int AW = PW - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_read;
`ifdef CACHE_RESP_LATENCY_STATS_EN
    logic [15:0]      stamp;
`endif
  } trk_t;

  state_t state, state_n;

  logic [CNT_W-1:0] expected_q;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] completed;

  logic [PW-1:0] wr_ptr, rd_ptr;
  trk_t          mem [TRK_DEPTH];
  trk_t          head;
  trk_t          push_ent;

  logic run, full, empty;
  logic push, pop, out_hs, last_resp, start_acc;

  assign run           = (state == S_RUN);
  assign pending_count = wr_ptr - rd_ptr;
  assign full          = (pending_count == PW'(TRK_DEPTH));
  assign empty         = (wr_ptr == rd_ptr);
  assign head          = mem[rd_ptr[AW-1:0]];

  assign cmd_ready        = run & ~full & (issued < expected_q);
  assign cache_resp_ready = run & ~empty &
                            (~resp_out_valid | resp_out_ready);

  assign push      = cmd_valid & cmd_ready;
  assign pop       = cache_resp_valid & cache_resp_ready;
  assign out_hs    = resp_out_valid & resp_out_ready;
  assign last_resp = (completed == expected_q - CNT_W'(1));
  assign start_acc = start & (state != S_RUN);
  assign done      = (state == S_DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = (expected_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (out_hs && last_resp) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      expected_q <= '0;
      issued     <= '0;
      completed  <= '0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        expected_q <= expected_count;
        issued     <= '0;
        completed  <= '0;
      end else begin
        if (push)   issued    <= issued + CNT_W'(1);
        if (out_hs) completed <= completed + CNT_W'(1);
      end
    end
  end

`ifdef CACHE_RESP_LATENCY_STATS_EN
  logic [15:0] cyc;
  logic [15:0] lat;

  assign lat = cyc - head.stamp;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc     <= '0;
      lat_max <= '0;
      lat_sum <= '0;
    end else begin
      cyc <= cyc + 16'd1;
      if (start_acc) begin
        lat_max <= '0;
        lat_sum <= '0;
      end else if (pop) begin
        if (lat > lat_max) lat_max <= lat;
        lat_sum <= lat_sum + 32'(lat);
      end
    end
  end
`endif

  always_comb begin
    push_ent         = '0;
    push_ent.tag     = cmd_tag;
    push_ent.is_read = cmd_is_read;
`ifdef CACHE_RESP_LATENCY_STATS_EN
    push_ent.stamp   = cyc;
`endif
  end

  // Storage has no reset; only pointer state defines occupancy.
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      resp_out_valid   <= 1'b0;
      resp_out_tag     <= '0;
      resp_out_is_read <= 1'b0;
      resp_out_data    <= '0;
    end else if (pop) begin
      resp_out_valid   <= 1'b1;
      resp_out_tag     <= head.tag;
      resp_out_is_read <= head.is_read;
      resp_out_data    <= head.is_read ? cache_resp_data : '0;
    end else if (resp_out_ready) begin
      resp_out_valid   <= 1'b0;
    end
  end

endmodule
